lb_initiator: RTL and testbench

//   Local-bus initiator: bridges the CPU data port (req/gnt/rvalid) to the local CSR bus
//   (waddr/wdata/wen/wstrb/wready, raddr/ren/rdata/rvalid) that CSR blocks such as

---
 rtl/lb_initiator_pkg.sv | 28 ++
 rtl/lb_initiator_if.sv | 42 ++++
 rtl/lb_timeout_ctr.sv | 32 +++
 rtl/lb_initiator.sv | 149 ++++++++++++++
 tb/tb_lb_initiator.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lb_initiator_pkg.sv
// Shared types and constants for the local-bus initiator.
package lb_initiator_pkg;

  // Initiator FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2,
    StResp  = 2'd3
  } lb_state_e;

  // Read data returned to the CPU on any error response.
  localparam logic [31:0] LbErrRdata = 32'h0000_0000;

  // True when an address falls outside the peripheral window or is not word aligned.
  function automatic logic lb_addr_err(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
    return ((addr & ~mask) != base) || (addr[1:0] != 2'b00);
  endfunction

  // Window offset forwarded onto the local bus.
  function automatic logic [31:0] lb_offset(input logic [31:0] addr,
                                            input logic [31:0] mask);
    return addr & mask;
  endfunction

endpackage

// File: rtl/lb_initiator_if.sv
// CPU data port plus local CSR bus, bundled. The master modport is the initiator's view.
interface lb_initiator_if;
  // CPU data port
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  // Local CSR bus, write channel
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        wen;
  logic [3:0]  wstrb;
  logic        wready;
  // Local CSR bus, read channel
  logic [31:0] raddr;
  logic        ren;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output waddr, wdata, wen, wstrb,
    input  wready,
    output raddr, ren,
    input  rdata, rvalid
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  waddr, wdata, wen, wstrb,
    output wready,
    input  raddr, ren,
    output rdata, rvalid
  );
endinterface

// File: rtl/lb_timeout_ctr.sv
// Bus-wait counter: cleared when a strobe starts, flags expiry on the last allowed wait cycle.
module lb_timeout_ctr #(
  parameter int unsigned Timeout = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (Timeout > 0) ? $clog2(Timeout + 1) : 1;
  // Count value during the Timeout-th strobe cycle; unused when Timeout is 0.
  localparam logic [CntW-1:0] LastCnt = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q;

  // Count wait cycles; clear wins over enable.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Expire while still waiting on the cycle the count would reach Timeout.
  assign expire_o = (Timeout != 0) && en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/lb_initiator.sv
// Local-bus initiator: bridges the CPU req/gnt/rvalid port onto the local CSR bus,
// one transaction at a time, with window decode and a bus-wait timeout.
module lb_initiator
  import lb_initiator_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h4000_0000,
  parameter logic [31:0] AddrMask = 32'h0000_0FFF,
  parameter int unsigned Timeout  = 16
) (
  input logic           clk_i,
  input logic           rst_ni,
  lb_initiator_if.master bus
);

  lb_state_e   state_q;
  logic        wen_q;
  logic        ren_q;
  logic [31:0] waddr_q;
  logic [31:0] raddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        cpu_rvalid_q;
  logic        cpu_err_q;
  logic [31:0] cpu_rdata_q;

  logic        gnt;
  logic        req_err;
  logic        bus_wait;
  logic        tmo_clr;
  logic        tmo_expire;

  // Grant is combinational and only offered while idle.
  assign gnt     = (state_q == StIdle) && bus.cpu_req;
  assign req_err = lb_addr_err(bus.cpu_addr, BaseAddr, AddrMask);

  // A strobe cycle in which the slave has not yet completed the access.
  assign bus_wait = ((state_q == StWrite) && !bus.wready) ||
                    ((state_q == StRead)  && !bus.rvalid);
  assign tmo_clr  = gnt && !req_err;

  lb_timeout_ctr #(
    .Timeout (Timeout)
  ) u_timeout_ctr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (tmo_clr),
    .en_i     (bus_wait),
    .expire_o (tmo_expire)
  );

  // Transaction FSM with registered bus strobes and CPU response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      wen_q        <= 1'b0;
      ren_q        <= 1'b0;
      waddr_q      <= '0;
      raddr_q      <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cpu_req) begin
            if (req_err) begin
              // Decode error: answer directly, never touch the bus.
              state_q      <= StResp;
              cpu_rvalid_q <= 1'b1;
              cpu_err_q    <= 1'b1;
              cpu_rdata_q  <= LbErrRdata;
            end else if (bus.cpu_we) begin
              state_q <= StWrite;
              wen_q   <= 1'b1;
              waddr_q <= lb_offset(bus.cpu_addr, AddrMask);
              wdata_q <= bus.cpu_wdata;
              wstrb_q <= bus.cpu_be;
            end else begin
              state_q <= StRead;
              ren_q   <= 1'b1;
              raddr_q <= lb_offset(bus.cpu_addr, AddrMask);
            end
          end
        end

        StWrite: begin
          // Ready in the expiry cycle still completes the write cleanly.
          if (bus.wready) begin
            state_q      <= StResp;
            wen_q        <= 1'b0;
            cpu_rvalid_q <= 1'b1;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
          end else if (tmo_expire) begin
            state_q      <= StResp;
            wen_q        <= 1'b0;
            cpu_rvalid_q <= 1'b1;
            cpu_err_q    <= 1'b1;
            cpu_rdata_q  <= LbErrRdata;
          end
        end

        StRead: begin
          if (bus.rvalid) begin
            state_q      <= StResp;
            ren_q        <= 1'b0;
            cpu_rvalid_q <= 1'b1;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= bus.rdata;
          end else if (tmo_expire) begin
            state_q      <= StResp;
            ren_q        <= 1'b0;
            cpu_rvalid_q <= 1'b1;
            cpu_err_q    <= 1'b1;
            cpu_rdata_q  <= LbErrRdata;
          end
        end

        StResp: begin
          // Response pulse lasts exactly one cycle.
          state_q      <= StIdle;
          cpu_rvalid_q <= 1'b0;
          cpu_err_q    <= 1'b0;
          cpu_rdata_q  <= '0;
        end

        default: begin
          state_q <= StIdle;
          wen_q   <= 1'b0;
          ren_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_gnt    = gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_err    = cpu_err_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.wen        = wen_q;
  assign bus.wstrb      = wstrb_q;
  assign bus.raddr      = raddr_q;
  assign bus.ren        = ren_q;

endmodule

// File: tb/tb_lb_initiator.sv
// Randomised scoreboard bench for lb_initiator (Timeout=16) plus a directed Timeout=0 check.
module tb_lb_initiator;

  localparam logic [31:0] Base = 32'h4000_0000;
  localparam logic [31:0] Mask = 32'h0000_0FFF;
  localparam int unsigned Tmo  = 16;
  localparam int unsigned NtWait = 40;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          len;
  } strobe_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lb_initiator_if bus ();
  lb_initiator_if bus_nt ();

  lb_initiator #(
    .BaseAddr (Base),
    .AddrMask (Mask),
    .Timeout  (Tmo)
  ) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  lb_initiator #(
    .BaseAddr (Base),
    .AddrMask (Mask),
    .Timeout  (0)
  ) u_dut_nt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_nt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  strobe_t sq[$];
  resp_t   rq[$];

  // Slave model: completes after cur_wait stalled strobe cycles.
  int unsigned cur_wait = 0;
  logic [31:0] cur_rdata = 32'h0;
  int unsigned scnt = 0;
  always @(posedge clk) scnt <= (bus.wen || bus.ren) ? scnt + 1 : 0;
  assign bus.wready = bus.wen && (scnt == cur_wait);
  assign bus.rvalid = bus.ren && (scnt == cur_wait);
  assign bus.rdata  = cur_rdata;

  // Slow slave for the no-timeout instance.
  int unsigned nt_cnt = 0;
  always @(posedge clk) nt_cnt <= (bus_nt.wen || bus_nt.ren) ? nt_cnt + 1 : 0;
  assign bus_nt.wready = bus_nt.wen && (nt_cnt == NtWait);
  assign bus_nt.rvalid = bus_nt.ren && (nt_cnt == NtWait);
  assign bus_nt.rdata  = 32'h1234_5678;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // Response monitor: every CPU response must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.cpu_rvalid) begin
      if (rq.size() == 0) begin
        fail_now("resp_unexpected");
      end else begin
        resp_t e;
        e = rq.pop_front();
        chk("resp_rdata", 64'(bus.cpu_rdata), 64'(e.rdata));
        chk("resp_err", 64'(bus.cpu_err), 64'(e.err));
      end
    end
  end

  // Strobe monitor: each strobe burst must match a queued expectation in kind, fields, length.
  strobe_t mon_cur;
  bit      in_strobe = 1'b0;
  int      run = 0;
  always @(negedge clk) begin
    if (bus.wen && bus.ren) fail_now("wen_ren_both");
    if (bus.wen || bus.ren) begin
      if (!in_strobe) begin
        if (sq.size() == 0) fail_now("strobe_unexpected");
        else mon_cur = sq.pop_front();
        in_strobe = 1'b1;
        run = 0;
      end
      run++;
      chk("strobe_kind", 64'(bus.wen), 64'(mon_cur.we));
      if (mon_cur.we) begin
        chk("waddr", 64'(bus.waddr), 64'(mon_cur.addr));
        chk("wdata", 64'(bus.wdata), 64'(mon_cur.wdata));
        chk("wstrb", 64'(bus.wstrb), 64'(mon_cur.strb));
      end else begin
        chk("raddr", 64'(bus.raddr), 64'(mon_cur.addr));
      end
    end else if (in_strobe) begin
      chk("strobe_len", 64'(run), 64'(mon_cur.len));
      in_strobe = 1'b0;
    end
  end

  // One CPU transaction; expectations come from the address/timeout rules, not the DUT.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int unsigned w, input logic [31:0] rd);
    logic    aerr;
    logic    tmo;
    int      len;
    int      lat;
    bit      got;
    resp_t   r;
    strobe_t s;
    aerr    = ((addr & ~Mask) != Base) || (addr[1:0] != 2'b00);
    tmo     = (w >= Tmo);
    len     = tmo ? int'(Tmo) : int'(w) + 1;
    r.err   = aerr || tmo;
    r.rdata = (!r.err && !we) ? rd : 32'h0;
    rq.push_back(r);
    if (!aerr) begin
      s.we    = we;
      s.addr  = addr & Mask;
      s.wdata = wd;
      s.strb  = be;
      s.len   = len;
      sq.push_back(s);
    end
    cur_wait      = w;
    cur_rdata     = rd;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.cpu_be    = be;
    bus.cpu_req   = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.cpu_gnt;
    end
    if (!got) begin
      fail_now("gnt_wait");
      bus.cpu_req = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = bus.cpu_rvalid;
    end
    if (!got) fail_now("rvalid_wait");
    else chk("resp_latency", 64'(lat), aerr ? 64'd1 : 64'(len + 1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int unsigned w;
    int unsigned sel;
    bit          got;
    int          lat;
    int          ren_cnt;
    strobe_t     s;

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be = '0;
    bus_nt.cpu_req = 1'b0; bus_nt.cpu_we = 1'b0; bus_nt.cpu_addr = '0;
    bus_nt.cpu_wdata = '0; bus_nt.cpu_be = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", 64'(bus.wen), 64'd0);
    chk("rst_ren", 64'(bus.ren), 64'd0);
    chk("rst_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    chk("rst_err", 64'(bus.cpu_err), 64'd0);
    chk("rst_rdata", 64'(bus.cpu_rdata), 64'd0);
    chk("rst_waddr", 64'(bus.waddr), 64'd0);
    chk("rst_raddr", 64'(bus.raddr), 64'd0);
    chk("rst_wdata", 64'(bus.wdata), 64'd0);
    chk("rst_wstrb", 64'(bus.wstrb), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    do_txn(1'b1, 32'h4000_0000, 32'h0000_0A05, 4'hF, 0, 32'h0);
    do_txn(1'b0, 32'h4000_0004, 32'h0, 4'h0, 0, 32'h0000_0ABC);
    do_txn(1'b0, 32'h5000_0000, 32'h0, 4'hF, 0, 32'h1111_1111);
    do_txn(1'b0, 32'h4000_0002, 32'h0, 4'hF, 0, 32'h2222_2222);
    do_txn(1'b1, 32'h4000_0008, 32'hDEAD_BEEF, 4'h3, 3, 32'h0);
    do_txn(1'b0, 32'h4000_000C, 32'h0, 4'h0, 30, 32'h5555_5555);
    do_txn(1'b0, 32'h4000_0010, 32'h0, 4'h0, 15, 32'h7777_7777);
    do_txn(1'b1, 32'h4000_0014, 32'h0BAD_F00D, 4'hC, 16, 32'h0);
    do_txn(1'b1, 32'h4000_0018, 32'h0000_CAFE, 4'h0, 0, 32'h0);
    do_txn(1'b0, 32'h4000_0FFC, 32'h0, 4'h0, 1, 32'hA5A5_5A5A);

    // Randomised traffic
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7) a = Base | ($urandom & 32'h0000_0FFC);
      else if (sel < 8) a = Base | ($urandom & Mask) | 32'h1;
      else a = $urandom;
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), w, $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // Reset while a read is waiting: strobe cut after two cycles, no response.
    s.we = 1'b0; s.addr = 32'h0000_0020; s.wdata = '0; s.strb = '0; s.len = 2;
    sq.push_back(s);
    cur_wait = 100;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h4000_0020;
    bus.cpu_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus.cpu_gnt;
    end
    if (!got) fail_now("rst_gnt_wait");
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midrst_ren", 64'(bus.ren), 64'd0);
    chk("midrst_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 10; k++) begin
      a = Base | ($urandom & 32'h0000_0FFC);
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom);
    end

    // Timeout=0 instance: a 40-cycle stall still completes without error.
    bus_nt.cpu_we = 1'b0;
    bus_nt.cpu_addr = 32'h4000_0010;
    bus_nt.cpu_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bus_nt.cpu_gnt;
    end
    if (!got) fail_now("nt_gnt_wait");
    @(posedge clk);
    #1;
    bus_nt.cpu_req = 1'b0;
    got = 1'b0;
    lat = 0;
    ren_cnt = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (bus_nt.ren) ren_cnt++;
      got = bus_nt.cpu_rvalid;
      if (got) begin
        chk("nt_err", 64'(bus_nt.cpu_err), 64'd0);
        chk("nt_rdata", 64'(bus_nt.cpu_rdata), 64'h1234_5678);
      end
    end
    if (!got) fail_now("nt_rvalid_wait");
    chk("nt_ren_len", 64'(ren_cnt), 64'(NtWait + 1));
    chk("nt_latency", 64'(lat), 64'(NtWait + 2));

    repeat (3) @(posedge clk);
    chk("resp_queue_drained", 64'(rq.size()), 64'd0);
    chk("strobe_queue_drained", 64'(sq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
